// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared width, opcode and state definitions for the execution controller
package cpu_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [2:0] {
        LOAD = 3'b000,
        ADD  = 3'b001,
        SUB  = 3'b010,
        AND  = 3'b011,
        OR   = 3'b100,
        XOR  = 3'b101,
        SHL  = 3'b110,
        NOP  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        WRITE = 2'b10
    } state_t;

endpackage

// File: rtl/alu4.sv
// rtl/alu4.sv - combinational ALU for the single-cycle opcodes
// Ports:
//   a      : accumulator operand (captured R value)
//   b      : immediate operand
//   opcode : operation select; LOAD..XOR are meaningful, others pass a through
//   y      : result, modulo 2^WIDTH
//   cout   : carry-out for ADD, borrow for SUB, 0 otherwise
module alu4
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          opcode,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y    = a;
        cout = 1'b0;
        case (opcode)
            LOAD: y = b;
            ADD: begin
                y    = w_sum[WIDTH-1:0];
                cout = w_sum[WIDTH];
            end
            SUB: begin
                y    = a - b;
                cout = (a < b);
            end
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// rtl/cpu_exec_ctrl.sv - instruction execution controller driving the R register load port
// Ports:
//   clk, rst_n          : clock shared with R register, async active-low reset
//   instr_valid/ready   : instruction handshake; opcode/operand sampled on accept
//   R                   : current R register value, captured as accumulator on accept
//   S, R_EN             : registered result and one-cycle load enable for R
//   carry, zero         : flags of the most recent write
//   done                : one-cycle pulse when an instruction retires
module cpu_exec_ctrl
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    output logic             R_EN,
    output logic             carry,
    output logic             zero,
    output logic             done
);

    state_t           r_state;
    opcode_t          r_op;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_cnt;
    logic             r_shc;      // last bit shifted out during SHL
    logic             r_pend_c;   // carry waiting to be committed at the end of WRITE
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_zero;

    logic [WIDTH-1:0] w_y;
    logic             w_cout;

    alu4 u_alu (
        .a      (r_acc),
        .b      (r_operand),
        .opcode (r_op),
        .y      (w_y),
        .cout   (w_cout)
    );

    // Decoded from the state register so reset removes R_EN/done immediately.
    assign instr_ready = rst_n && (r_state == IDLE);
    assign R_EN        = (r_state == WRITE);
    assign done        = (r_state == WRITE) || ((r_state == EXEC) && (r_op == NOP));
    assign S           = r_s;
    assign carry       = r_carry;
    assign zero        = r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= LOAD;
            r_operand <= '0;
            r_acc     <= '0;
            r_cnt     <= 2'd0;
            r_shc     <= 1'b0;
            r_pend_c  <= 1'b0;
            r_s       <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_op      <= opcode_t'(opcode);
                        r_operand <= operand;
                        r_acc     <= R;
                        r_cnt     <= operand[1:0];
                        r_shc     <= 1'b0;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    case (r_op)
                        NOP: r_state <= IDLE;
                        SHL: begin
                            if (r_cnt != 2'd0) begin
                                r_acc <= {r_acc[WIDTH-2:0], 1'b0};
                                r_shc <= r_acc[WIDTH-1];
                                r_cnt <= r_cnt - 2'd1;
                            end else begin
                                r_s      <= r_acc;
                                r_pend_c <= r_shc;
                                r_state  <= WRITE;
                            end
                        end
                        default: begin
                            r_s      <= w_y;
                            r_pend_c <= w_cout;
                            r_state  <= WRITE;
                        end
                    endcase
                end
                WRITE: begin
                    r_carry <= r_pend_c;
                    r_zero  <= (r_s == '0);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb/tb_cpu_exec_ctrl.sv - self-checking bench for cpu_exec_ctrl with an R register model
module tb_cpu_exec_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] opcode = 3'd0;
    logic [3:0] operand = 4'd0;
    logic [3:0] R;
    logic [3:0] S;
    logic       R_EN, carry, zero, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ren_pulses = 0;

    // observations of the last run_instr
    int         o_ren_first, o_ren_cnt, o_done_first, o_done_cnt;
    logic [3:0] o_s_wr;
    logic       o_glitch;

    // model state
    logic [3:0] m_r, m_s;
    logic       m_c, m_z;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) R <= 4'd0;
        else if (R_EN) R <= S;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (R_EN) ren_pulses <= ren_pulses + 1;
    end

    cpu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .R(R), .S(S), .R_EN(R_EN),
        .carry(carry), .zero(zero), .done(done)
    );

    // Reference: {carry, result} from the opcode rules.
    function automatic logic [4:0] ref_exec(input logic [2:0] op, input logic [3:0] acc, input logic [3:0] od);
        int a = acc;
        int b = od;
        int r = 0;
        int c = 0;
        int n;
        logic [3:0] rr;
        case (op)
            3'd0: r = b;
            3'd1: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            3'd2: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin
                n = b % 4;
                r = (a * (2 ** n)) % 16;
                c = (n == 0) ? 0 : ((a / (2 ** (4 - n))) % 2);
            end
            default: r = a;
        endcase
        rr = r[3:0];
        return {c[0], rr};
    endfunction

    task automatic run_instr(input logic [2:0] op, input logic [3:0] od);
        int w = 0;
        logic [3:0] s_prev;
        @(negedge clk);
        instr_valid = 1'b1; opcode = op; operand = od;
        while (!instr_ready && w < 20) begin @(negedge clk); w++; end
        if (!instr_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: instr_ready=%0b required 1", instr_ready);
            instr_valid = 1'b0;
            return;
        end
        s_prev = S;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        o_ren_first = -1; o_ren_cnt = 0; o_done_first = -1; o_done_cnt = 0;
        o_s_wr = 4'hx; o_glitch = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (R_EN) begin
                if (o_ren_first < 0) o_ren_first = i;
                o_ren_cnt++;
                o_s_wr = S;
            end else if (S !== s_prev) o_glitch = 1'b1;
            if (done) begin
                if (o_done_first < 0) o_done_first = i;
                o_done_cnt++;
            end
            s_prev = S;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({instr_ready, S, R_EN, carry, zero, done} !== 9'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b required 000000000", {instr_ready, S, R_EN, carry, zero, done});
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", instr_ready); end
        m_r = 0; m_s = 0; m_c = 0; m_z = 0;
    endtask

    task automatic test_add();
        run_instr(LOAD, 4'hC);
        run_instr(ADD, 4'h7);
        n_cmp++; if (o_s_wr !== 4'h3) begin n_bad++; $display("FAIL add_s: got %h required 3", o_s_wr); end
        n_cmp++; if (o_ren_first !== 1 || o_ren_cnt !== 1) begin n_bad++; $display("FAIL add_ren: first %0d cnt %0d required 1 1", o_ren_first, o_ren_cnt); end
        n_cmp++; if (o_done_first !== 1 || o_done_cnt !== 1) begin n_bad++; $display("FAIL add_done: first %0d cnt %0d required 1 1", o_done_first, o_done_cnt); end
        n_cmp++; if ({carry, zero} !== 2'b10) begin n_bad++; $display("FAIL add_flags: got %b required 10", {carry, zero}); end
        n_cmp++; if (R !== 4'h3) begin n_bad++; $display("FAIL add_r: got %h required 3", R); end
    endtask

    task automatic test_sub();
        run_instr(LOAD, 4'h3);
        run_instr(SUB, 4'h3);
        n_cmp++; if ({o_s_wr, carry, zero} !== {4'h0, 2'b01}) begin n_bad++; $display("FAIL sub_eq: got %h c%b z%b required 0 c0 z1", o_s_wr, carry, zero); end
        run_instr(SUB, 4'h5);
        n_cmp++; if ({o_s_wr, carry, zero} !== {4'hB, 2'b10}) begin n_bad++; $display("FAIL sub_borrow: got %h c%b z%b required b c1 z0", o_s_wr, carry, zero); end
    endtask

    task automatic test_shl();
        run_instr(LOAD, 4'b1011);
        run_instr(SHL, 4'd2);
        n_cmp++; if ({o_s_wr, carry} !== {4'b1100, 1'b0}) begin n_bad++; $display("FAIL shl2_result: got %b c%b required 1100 c0", o_s_wr, carry); end
        n_cmp++; if (o_ren_first !== 3) begin n_bad++; $display("FAIL shl2_latency: R_EN at %0d required 3", o_ren_first); end
        run_instr(LOAD, 4'b1011);
        run_instr(ADD, 4'b1111);
        run_instr(LOAD, 4'b1011);
        run_instr(SHL, 4'd0);
        n_cmp++; if ({o_s_wr, carry} !== {4'b1011, 1'b0}) begin n_bad++; $display("FAIL shl0_result: got %b c%b required 1011 c0", o_s_wr, carry); end
        n_cmp++; if (o_ren_first !== 1) begin n_bad++; $display("FAIL shl0_latency: R_EN at %0d required 1", o_ren_first); end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, p0, w;
        p0 = ren_pulses;
        @(negedge clk);
        instr_valid = 1'b1; opcode = LOAD; operand = 4'h9;
        for (w = 0; w < 20 && !instr_ready; w++) @(negedge clk);
        if (instr_ready) t1 = cyc + 1;
        @(posedge clk); @(negedge clk);
        opcode = XOR; operand = 4'hF;
        for (w = 0; w < 20; w++) begin
            if (instr_ready) begin t2 = cyc + 1; break; end
            @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (t1 < 0 || t2 - t1 !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d required 3", t2 - t1); end
        n_cmp++; if (S !== 4'h6 || R !== 4'h6) begin n_bad++; $display("FAIL b2b_result: S %h R %h required 6", S, R); end
        n_cmp++; if (ren_pulses - p0 !== 2) begin n_bad++; $display("FAIL b2b_writes: got %0d required 2", ren_pulses - p0); end
    endtask

    task automatic test_nop();
        run_instr(LOAD, 4'hC);
        run_instr(ADD, 4'h7);
        run_instr(NOP, 4'h5);
        n_cmp++; if (o_ren_cnt !== 0) begin n_bad++; $display("FAIL nop_ren: got %0d pulses required 0", o_ren_cnt); end
        n_cmp++; if (o_done_first !== 0 || o_done_cnt !== 1) begin n_bad++; $display("FAIL nop_done: first %0d cnt %0d required 0 1", o_done_first, o_done_cnt); end
        n_cmp++; if ({S, carry, zero} !== {4'h3, 2'b10}) begin n_bad++; $display("FAIL nop_hold: got %h c%b z%b required 3 c1 z0", S, carry, zero); end
    endtask

    task automatic test_reset_mid();
        run_instr(LOAD, 4'hC);
        run_instr(ADD, 4'h7);
        @(negedge clk);
        instr_valid = 1'b1; opcode = SHL; operand = 4'd2;
        @(posedge clk);
        repeat (4) @(negedge clk);
        instr_valid = 1'b0;
        n_cmp++; if (R_EN !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: R_EN %b required 1", R_EN); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({R_EN, S, carry, zero, done, instr_ready} !== 9'b0) begin
            n_bad++; $display("FAIL rstmid_clear: got %b required 000000000", {R_EN, S, carry, zero, done, instr_ready});
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (instr_ready !== 1'b1 || R !== 4'h0) begin n_bad++; $display("FAIL rstmid_idle: ready %b R %h required 1 0", instr_ready, R); end
        m_r = 0; m_s = 0; m_c = 0; m_z = 0;
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] od;
        logic [4:0] e;
        int exp_first;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            od = 4'($urandom_range(0, 15));
            e = ref_exec(op, m_r, od);
            run_instr(op, od);
            if (op == 3'd7) begin
                n_cmp++; if (o_ren_cnt !== 0 || o_done_first !== 0 || o_done_cnt !== 1 || {S, carry, zero} !== {m_s, m_c, m_z}) begin
                    n_bad++; $display("FAIL rand_nop[%0d]: ren %0d done@%0d S %h c%b z%b required ren 0 done@0 S %h c%b z%b", k, o_ren_cnt, o_done_first, S, carry, zero, m_s, m_c, m_z);
                end
            end else begin
                exp_first = (op == 3'd6) ? 1 + od % 4 : 1;
                m_s = e[3:0]; m_c = e[4]; m_z = (e[3:0] == 4'd0); m_r = e[3:0];
                n_cmp++; if (o_ren_first !== exp_first || o_ren_cnt !== 1 || o_done_first !== exp_first || o_done_cnt !== 1) begin
                    n_bad++; $display("FAIL rand_timing[%0d] op%0d: ren@%0d x%0d done@%0d x%0d required @%0d x1", k, op, o_ren_first, o_ren_cnt, o_done_first, o_done_cnt, exp_first);
                end
                n_cmp++; if ({o_s_wr, carry, zero, R} !== {m_s, m_c, m_z, m_r}) begin
                    n_bad++; $display("FAIL rand_result[%0d] op%0d od%h: S %h c%b z%b R %h required S %h c%b z%b R %h", k, op, od, o_s_wr, carry, zero, R, m_s, m_c, m_z, m_r);
                end
            end
            n_cmp++; if (o_glitch !== 1'b0) begin n_bad++; $display("FAIL rand_s_stable[%0d]: S moved while R_EN low", k); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shl();
        test_back_to_back();
        test_nop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
